neuron_stream_ctrl: RTL and testbench

Streaming front/back-end wrapper for one ReLU neuron datapath (3 FP32 multipliers, adder tree, ReLU). Holds the neuron's weights and bias, and accepts input vectors over a valid/ready stream. Tracks the neuron's fixed pipeline latency with a valid shift chain, since the neuron has no valid signal. Collects results in an output FIFO, with credit-based admission so no result is ever lost under backpressure.

---
 rtl/neuron_stream_ctrl.sv | 123 ++++++++++++
 tb/tb_neuron_stream_ctrl.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_stream_ctrl.sv
// Stream wrapper for one ReLU neuron: weight/bias registers, input staging, latency-tracking valid chain, credit-gated result FIFO.
// Optional feature macro: NEURON_ZERO_CNT_EN adds the zero_cnt output.
module neuron_stream_ctrl #(
    parameter int unsigned N_IN       = 3,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned PIPE_LAT   = 9,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [DATA_W-1:0]            s_data [N_IN-1:0],
    input  logic                         w_we,
    input  logic [$clog2(N_IN+1)-1:0]    w_addr,
    input  logic [DATA_W-1:0]            w_data,
    output logic                         w_ready,
    output logic [DATA_W-1:0]            neuron_input [N_IN-1:0],
    output logic [DATA_W-1:0]            weights [N_IN-1:0],
    output logic [DATA_W-1:0]            bias,
    input  logic [DATA_W-1:0]            neuron_output,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [DATA_W-1:0]            m_data
`ifdef NEURON_ZERO_CNT_EN
   ,output logic [15:0]                  zero_cnt
`endif
);

    localparam int unsigned AW = $clog2(N_IN + 1);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1) + 1;
    localparam logic [AW:0] ADDR_MAX = (AW+1)'(N_IN);

    // One stage more than PIPE_LAT: neuron_input is itself a register in front of the neuron.
    logic [PIPE_LAT:0]  vchain;
    logic [CW-1:0]      inflight;
    logic [CW-1:0]      fifo_count;
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [DATA_W-1:0]  mem [FIFO_DEPTH];

    logic accept;
    logic push;
    logic pop;
    logic wr_ok;

    assign accept  = s_valid && s_ready;
    assign push    = vchain[PIPE_LAT];
    assign pop     = m_valid && m_ready;
    assign w_ready = (inflight == '0);
    assign wr_ok   = w_we && w_ready && ({1'b0, w_addr} <= ADDR_MAX);
    // Admission counts every outstanding result, so a full FIFO can always absorb the pipeline.
    assign s_ready = reset && !w_we && ((fifo_count + inflight) < CW'(FIFO_DEPTH));
    assign m_valid = (fifo_count != '0);
    assign m_data  = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vchain     <= '0;
            inflight   <= '0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            bias       <= '0;
            for (int unsigned i = 0; i < N_IN; i++) begin
                neuron_input[i] <= '0;
                weights[i]      <= '0;
            end
        end else begin
            vchain <= {vchain[PIPE_LAT-1:0], accept};
            if (accept) begin
                neuron_input <= s_data;
            end

            case ({accept, push})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: ;
            endcase

            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: ;
            endcase
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end

            for (int unsigned i = 0; i < N_IN; i++) begin
                if (wr_ok && (w_addr == AW'(i))) begin
                    weights[i] <= w_data;
                end
            end
            if (wr_ok && (w_addr == AW'(N_IN))) begin
                bias <= w_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= neuron_output;
        end
    end

`ifdef NEURON_ZERO_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            zero_cnt <= '0;
        end else if (wr_ok) begin
            zero_cnt <= '0;
        end else if (push && (neuron_output == '0) && (zero_cnt != '1)) begin
            zero_cnt <= zero_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_neuron_stream_ctrl.sv
// Self-checking bench for neuron_stream_ctrl with a behavioural FP neuron stand-in and a queue-based reference model.
module tb_neuron_stream_ctrl;

    localparam int unsigned N_IN       = 3;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned PIPE_LAT   = 9;
    localparam int unsigned FIFO_DEPTH = 4;

    typedef logic [31:0] vec_t [N_IN-1:0];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    vec_t        s_data;
    logic        w_we = 1'b0;
    logic [1:0]  w_addr = 2'd0;
    logic [31:0] w_data = 32'h0;
    logic        w_ready;
    vec_t        neuron_input;
    vec_t        weights;
    logic [31:0] bias;
    logic [31:0] neuron_output;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
`ifdef NEURON_ZERO_CNT_EN
    logic [15:0] zero_cnt;
`endif

    neuron_stream_ctrl #(
        .N_IN(N_IN), .DATA_W(DATA_W), .PIPE_LAT(PIPE_LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .w_ready(w_ready),
        .neuron_input(neuron_input), .weights(weights), .bias(bias),
        .neuron_output(neuron_output),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
`ifdef NEURON_ZERO_CNT_EN
       ,.zero_cnt(zero_cnt)
`endif
    );

    always #5 clk = ~clk;

    // FP32 helpers for normal numbers and zero (stimulus stays in exactly representable values)
    function automatic real f32_to_real(input logic [31:0] b);
        logic [63:0] d;
        if (b[30:0] == 31'd0) return 0.0;
        d = {b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] real_to_f32(input real r);
        logic [63:0] d;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    function automatic logic [31:0] neuron_f(input vec_t x, input vec_t w, input logic [31:0] b);
        real acc;
        acc = f32_to_real(b);
        for (int i = 0; i < N_IN; i++) acc += f32_to_real(x[i]) * f32_to_real(w[i]);
        return (acc > 0.0) ? real_to_f32(acc) : 32'h0;
    endfunction

    function automatic logic [31:0] rnd_val(input int span);
        int k;
        k = int'($urandom_range(2 * span, 0)) - span;
        return real_to_f32(real'(k) * 0.5);
    endfunction

    // Environment stand-in for the neuron: fixed PIPE_LAT-clock pipeline on the DUT's outputs
    logic [31:0] npipe [PIPE_LAT];
    always @(posedge clk) begin
        npipe[0] <= neuron_f(neuron_input, weights, bias);
        for (int k = 1; k < PIPE_LAT; k++) npipe[k] <= npipe[k-1];
    end
    assign neuron_output = npipe[PIPE_LAT-1];

    // Reference model: results ordered by acceptance; each result leaves the pipe PIPE_LAT+1 edges after its accept
    int unsigned cyc = 0;
    int unsigned acc_cyc [$];
    logic [31:0] res_q [$];
    vec_t        mw;
    logic [31:0] mb;
    int unsigned mzc;

    logic [34:0] exp_v, obs_v;
    logic        obs_sr, obs_wr, obs_mv, exp_acc;
    logic [31:0] obs_md;
    int          ncmp = 0;
    int          nfail = 0;

    task automatic model_clear();
        res_q.delete();
        acc_cyc.delete();
        for (int i = 0; i < N_IN; i++) mw[i] = 32'h0;
        mb  = 32'h0;
        mzc = 0;
    endtask

    // Capture outputs and model expectations mid-cycle, take one clock, advance the model
    task automatic step();
        int unsigned n_fifo;
        logic esr, ewr, emv;
        logic [31:0] pushed;
        #1;
        n_fifo  = res_q.size() - acc_cyc.size();
        esr     = rst_n && (res_q.size() < FIFO_DEPTH) && !w_we;
        ewr     = (acc_cyc.size() == 0);
        emv     = (n_fifo > 0);
        exp_v   = {esr, ewr, emv, emv ? res_q[0] : 32'h0};
        obs_sr  = s_ready;
        obs_wr  = w_ready;
        obs_mv  = m_valid;
        obs_md  = m_data;
        obs_v   = {s_ready, w_ready, m_valid, emv ? m_data : 32'h0};
        exp_acc = s_valid && esr;
        @(posedge clk);
        cyc++;
        if (rst_n) begin
            if (acc_cyc.size() > 0 && acc_cyc[0] + PIPE_LAT + 1 == cyc) begin
                pushed = res_q[n_fifo];
                void'(acc_cyc.pop_front());
                if (pushed == 32'h0 && mzc < 65535) mzc++;
            end
            if (emv && m_ready) void'(res_q.pop_front());
            if (exp_acc) begin
                res_q.push_back(neuron_f(s_data, mw, mb));
                acc_cyc.push_back(cyc);
            end
            if (w_we && ewr) begin
                if (w_addr == 2'd3) mb = w_data;
                else mw[w_addr] = w_data;
                mzc = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        s_valid = 1'b0; w_we = 1'b1; w_addr = a; w_data = d;
        step();
        w_we = 1'b0;
    endtask

    task automatic rand_vec(output vec_t v);
        for (int i = 0; i < N_IN; i++) v[i] = rnd_val(4);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        #1;
        ncmp++;
        if ({s_ready, m_valid, w_ready} !== 3'b001) begin
            nfail++; $display("FAIL reset_hs got %b want 001", {s_ready, m_valid, w_ready});
        end
        ncmp++;
        if ({weights[0], weights[1], weights[2], bias, neuron_input[0], neuron_input[1], neuron_input[2]} !== 224'h0) begin
            nfail++; $display("FAIL reset_regs got w0=%h w1=%h w2=%h b=%h", weights[0], weights[1], weights[2], bias);
        end
`ifdef NEURON_ZERO_CNT_EN
        ncmp++;
        if (zero_cnt !== 16'd0) begin nfail++; $display("FAIL reset_zc got %0d want 0", zero_cnt); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); ncmp++;
            if (obs_v !== exp_v) begin nfail++; $display("FAIL reset_idle cyc=%0d got %h want %h", cyc, obs_v, exp_v); end
        end
    endtask

    task automatic test_basic();
        int k;
        logic found;
        logic [31:0] md;
        m_ready = 1'b1;
        wr(2'd0, 32'h3F800000); wr(2'd1, 32'h40000000); wr(2'd2, 32'h3F000000); wr(2'd3, 32'hBF800000);
        ncmp++;
        if ({weights[0], weights[1], weights[2], bias} !== {32'h3F800000, 32'h40000000, 32'h3F000000, 32'hBF800000}) begin
            nfail++; $display("FAIL basic_wregs got %h %h %h %h", weights[0], weights[1], weights[2], bias);
        end
        s_data[0] = 32'h3F800000; s_data[1] = 32'h3F800000; s_data[2] = 32'h40000000;
        s_valid = 1'b1;
        step(); ncmp++;
        if (obs_v !== exp_v) begin nfail++; $display("FAIL basic_acc cyc=%0d got %h want %h", cyc, obs_v, exp_v); end
        s_valid = 1'b0;
        k = 0; found = 1'b0; md = 32'h0;
        for (int i = 0; i < 30 && !found; i++) begin
            step(); ncmp++;
            if (obs_v !== exp_v) begin nfail++; $display("FAIL basic_step cyc=%0d got %h want %h", cyc, obs_v, exp_v); end
            if (obs_mv) begin found = 1'b1; md = obs_md; end
            else k++;
        end
        ncmp++;
        if (!found || k != int'(PIPE_LAT + 1)) begin
            nfail++; $display("FAIL basic_latency got %0d (seen=%0b) want %0d", k, found, PIPE_LAT + 1);
        end
        ncmp++;
        if (md !== 32'h40400000) begin nfail++; $display("FAIL basic_data got %h want 40400000", md); end
    endtask

    task automatic test_zero();
        logic found;
        logic [31:0] md;
        m_ready = 1'b1;
        for (int i = 0; i < N_IN; i++) s_data[i] = 32'hBF800000;
        s_valid = 1'b1;
        step(); ncmp++;
        if (obs_v !== exp_v) begin nfail++; $display("FAIL zero_acc cyc=%0d got %h want %h", cyc, obs_v, exp_v); end
        s_valid = 1'b0;
        found = 1'b0; md = 32'hFFFFFFFF;
        for (int i = 0; i < 30 && !found; i++) begin
            step(); ncmp++;
            if (obs_v !== exp_v) begin nfail++; $display("FAIL zero_step cyc=%0d got %h want %h", cyc, obs_v, exp_v); end
            if (obs_mv) begin found = 1'b1; md = obs_md; end
        end
        ncmp++;
        if (!found || md !== 32'h0) begin nfail++; $display("FAIL zero_data got %h (seen=%0b) want 00000000", md, found); end
`ifdef NEURON_ZERO_CNT_EN
        ncmp++;
        if (zero_cnt !== 16'd1) begin nfail++; $display("FAIL zero_cnt got %0d want 1", zero_cnt); end
`endif
    endtask

    task automatic test_backpressure();
        vec_t vecs [6];
        int idx, pops;
        for (int i = 0; i < 6; i++) rand_vec(vecs[i]);
        m_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            s_valid = (idx < 6);
            s_data  = vecs[idx < 6 ? idx : 5];
            step(); ncmp++;
            if (obs_v !== exp_v) begin nfail++; $display("FAIL bp_hold cyc=%0d got %h want %h", cyc, obs_v, exp_v); end
            if (exp_acc) idx++;
        end
        ncmp++;
        if (idx != 4) begin nfail++; $display("FAIL bp_accepted got %0d want 4", idx); end
        m_ready = 1'b1;
        pops = 0;
        for (int c = 0; c < 80 && !(idx == 6 && res_q.size() == 0); c++) begin
            s_valid = (idx < 6);
            s_data  = vecs[idx < 6 ? idx : 5];
            step(); ncmp++;
            if (obs_v !== exp_v) begin nfail++; $display("FAIL bp_drain cyc=%0d got %h want %h", cyc, obs_v, exp_v); end
            if (exp_acc) idx++;
            if (obs_mv) pops++;
        end
        s_valid = 1'b0;
        ncmp++;
        if (pops != 6 || idx != 6) begin nfail++; $display("FAIL bp_total got pops=%0d acc=%0d want 6/6", pops, idx); end
    endtask

    task automatic test_weight_drop();
        logic found;
        logic [31:0] md;
        m_ready = 1'b1;
        s_data[0] = 32'h3F800000; s_data[1] = 32'h3F800000; s_data[2] = 32'h40000000;
        s_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(); ncmp++;
            if (obs_v !== exp_v) begin nfail++; $display("FAIL wd_acc cyc=%0d got %h want %h", cyc, obs_v, exp_v); end
        end
        w_we = 1'b1; w_addr = 2'd0; w_data = 32'h40800000;
        step(); ncmp++;
        if ({obs_sr, obs_wr} !== 2'b00) begin nfail++; $display("FAIL wd_busy got sr/wr=%b want 00", {obs_sr, obs_wr}); end
        w_we = 1'b0; s_valid = 1'b0;
        for (int c = 0; c < 40 && res_q.size() != 0; c++) begin
            step(); ncmp++;
            if (obs_v !== exp_v) begin nfail++; $display("FAIL wd_drain cyc=%0d got %h want %h", cyc, obs_v, exp_v); end
        end
        ncmp++;
        if (weights[0] !== 32'h3F800000) begin nfail++; $display("FAIL wd_dropped got %h want 3f800000", weights[0]); end
        w_we = 1'b1; s_valid = 1'b1;
        step(); ncmp++;
        if ({obs_sr, obs_wr} !== 2'b01) begin nfail++; $display("FAIL wd_retry got sr/wr=%b want 01", {obs_sr, obs_wr}); end
        w_we = 1'b0;
        ncmp++;
        if (weights[0] !== 32'h40800000) begin nfail++; $display("FAIL wd_written got %h want 40800000", weights[0]); end
        step(); ncmp++;
        if (obs_v !== exp_v) begin nfail++; $display("FAIL wd_newacc cyc=%0d got %h want %h", cyc, obs_v, exp_v); end
        s_valid = 1'b0;
        found = 1'b0; md = 32'h0;
        for (int i = 0; i < 30 && !found; i++) begin
            step(); ncmp++;
            if (obs_v !== exp_v) begin nfail++; $display("FAIL wd_step cyc=%0d got %h want %h", cyc, obs_v, exp_v); end
            if (obs_mv) begin found = 1'b1; md = obs_md; end
        end
        ncmp++;
        if (!found || md !== 32'h40C00000) begin nfail++; $display("FAIL wd_newdata got %h (seen=%0b) want 40c00000", md, found); end
    endtask

    task automatic test_stream();
        vec_t v;
        int idx, pops;
        for (int a = 0; a <= N_IN; a++) wr(2'(a), rnd_val(4));
        m_ready = 1'b1;
        idx = 0; pops = 0;
        rand_vec(v);
        for (int c = 0; c < 300 && !(idx == 20 && res_q.size() == 0); c++) begin
            s_valid = (idx < 20);
            s_data  = v;
            if (c >= 60) m_ready = ($urandom_range(3, 0) != 0);
            step(); ncmp++;
            if (obs_v !== exp_v) begin nfail++; $display("FAIL stream cyc=%0d got %h want %h", cyc, obs_v, exp_v); end
            if (exp_acc) begin idx++; rand_vec(v); end
            if (obs_mv && m_ready) pops++;
        end
        s_valid = 1'b0; m_ready = 1'b1;
        ncmp++;
        if (pops != 20 || idx != 20) begin nfail++; $display("FAIL stream_total got pops=%0d acc=%0d want 20/20", pops, idx); end
`ifdef NEURON_ZERO_CNT_EN
        ncmp++;
        if (zero_cnt !== 16'(mzc)) begin nfail++; $display("FAIL stream_zc got %0d want %0d", zero_cnt, mzc); end
`endif
    endtask

    task automatic test_reset_mid();
        vec_t v;
        int seen;
        m_ready = 1'b0;
        for (int c = 0; c < 14; c++) begin
            rand_vec(v);
            s_data  = v;
            s_valid = (c < 2) || (c == 10) || (c == 11);
            step(); ncmp++;
            if (obs_v !== exp_v) begin nfail++; $display("FAIL rm_fill cyc=%0d got %h want %h", cyc, obs_v, exp_v); end
        end
        s_valid = 1'b0;
        ncmp++;
        if (res_q.size() != 4 || acc_cyc.size() != 2) begin
            nfail++; $display("FAIL rm_setup got outstanding=%0d inflight=%0d want 4/2", res_q.size(), acc_cyc.size());
        end
        #2 rst_n = 1'b0;
        model_clear();
        #1;
        ncmp++;
        if ({m_valid, s_ready} !== 2'b00) begin nfail++; $display("FAIL rm_async got mv/sr=%b want 00", {m_valid, s_ready}); end
        ncmp++;
        if ({weights[0], weights[1], weights[2], bias} !== 128'h0) begin
            nfail++; $display("FAIL rm_weights got %h %h %h %h", weights[0], weights[1], weights[2], bias);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            step(); ncmp++;
            if (obs_v !== exp_v) begin nfail++; $display("FAIL rm_after cyc=%0d got %h want %h", cyc, obs_v, exp_v); end
            if (obs_mv) seen++;
        end
        ncmp++;
        if (seen != 0) begin nfail++; $display("FAIL rm_stale got %0d results want 0", seen); end
    endtask

    initial begin
        for (int i = 0; i < N_IN; i++) s_data[i] = 32'h0;
        model_clear();
        test_reset();
        test_basic();
        test_zero();
        test_backpressure();
        test_weight_drop();
        test_stream();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
